// File: rtl/box_plotter.sv
// box_plotter
//   Takes one box request (top-left x, y, colour) per valid/ready handshake
//   and expands it into a BOX_W x BOX_H row-major run of single-pixel writes
//   for the VGA adapter. Pixels that fall off screen are suppressed, but the
//   scan still steps through them, so every box takes the same number of cycles.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a request; in_ready = 1
//   S_DRAW | one pixel per cycle from the latched box; plot when on screen
//   S_DONE | one-cycle done pulse, then back to S_IDLE
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   in_valid / in_ready        request handshake
//   in_x, in_y, in_colour      box top-left corner and colour
//   vga_x, vga_y, vga_colour   pixel to the adapter write port
//   plot                       adapter write enable
//   done                       one-cycle pulse after the last pixel of a box
module box_plotter #(
  parameter int BOX_W    = 3,
  parameter int BOX_H    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] DX_LAST = 4'(BOX_W - 1);
  localparam logic [3:0] DY_LAST = 4'(BOX_H - 1);

  state_t     state, state_nxt;
  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] col;
  logic [3:0] dx, dy;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       accept;
  logic       row_end;
  logic       last_px;
  logic       on_screen;

  // Widened so a box hanging off the right/bottom edge compares correctly
  // instead of wrapping back onto the screen.
  assign sum_x     = {1'b0, bx} + {5'd0, dx};
  assign sum_y     = {1'b0, by} + {4'd0, dy};
  assign on_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));

  assign row_end = (dx == DX_LAST);
  assign last_px = row_end && (dy == DY_LAST);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_DRAW;
      S_DRAW:  if (last_px) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    plot       = 1'b0;
    done       = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    case (state)
      S_DRAW: begin
        plot       = on_screen;
        vga_x      = sum_x[7:0];
        vga_y      = sum_y[6:0];
        vga_colour = col;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Gated by reset so the handshake is closed while reset is held.
  assign in_ready = (state == S_IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx  <= 8'd0;
      by  <= 7'd0;
      col <= 3'd0;
      dx  <= 4'd0;
      dy  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bx  <= in_x;
            by  <= in_y;
            col <= in_colour;
            dx  <= 4'd0;
            dy  <= 4'd0;
          end
        end
        S_DRAW: begin
          if (row_end) begin
            dx <= 4'd0;
            dy <= dy + 4'd1;
          end else begin
            dx <= dx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_box_plotter.sv
module tb_box_plotter;

  localparam int W = 3;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       done;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_in_x;
  logic [6:0] s_in_y;
  logic [2:0] s_in_colour;
  logic [7:0] s_vga_x;
  logic [6:0] s_vga_y;
  logic [2:0] s_vga_colour;
  logic       s_plot;
  logic       s_done;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: k = 0 idle, 1..N pixel k of the box, N+1 done cycle
  int k = 0;
  int mbx, mby, mcol;

  always #5 clk = ~clk;

  box_plotter #(.BOX_W(W), .BOX_H(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .done(done)
  );

  box_plotter #(.BOX_W(1), .BOX_H(1)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_x(s_in_x), .in_y(s_in_y), .in_colour(s_in_colour),
    .vga_x(s_vga_x), .vga_y(s_vga_y), .vga_colour(s_vga_colour),
    .plot(s_plot), .done(s_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the rising edge using the inputs the
  // DUT sees, then compare every output at the falling edge.
  task automatic step();
    int p, ex, ey;
    @(posedge clk);
    if (reset) k = 0;
    else if (k == 0) begin
      if (in_valid) begin
        mbx = in_x; mby = in_y; mcol = in_colour; k = 1;
      end
    end else if (k == N + 1) k = 0;
    else k = k + 1;
    @(negedge clk);
    chk("in_ready", in_ready, (k == 0 && !reset) ? 1 : 0);
    chk("done", done, (k == N + 1) ? 1 : 0);
    if (k >= 1 && k <= N) begin
      p  = k - 1;
      ex = mbx + p % W;
      ey = mby + p / W;
      chk("plot", plot, (ex < 160 && ey < 120) ? 1 : 0);
      chk("vga_x", vga_x, ex % 256);
      chk("vga_y", vga_y, ey % 128);
      chk("vga_colour", vga_colour, mcol);
    end else begin
      chk("plot_idle", plot, 0);
    end
  endtask

  // Issue one request from idle, scramble the request bus while drawing,
  // and check plot count and done position (acceptance cycle counts as 1).
  task automatic run_req(input int x, input int y, input int c, input int exp_plots);
    int cyc, plots;
    in_valid = 1'b1; in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c);
    step();
    in_valid = 1'b0;
    cyc = 1; plots = plot ? 1 : 0;
    while (!done && cyc < 40) begin
      in_x = 8'($urandom); in_y = 7'($urandom); in_colour = 3'($urandom);
      step();
      cyc++;
      if (plot) plots++;
    end
    chk("done_cycle", cyc, N + 1);
    chk("plot_count", plots, exp_plots);
    step();
    chk("ready_after_done", in_ready, 1);
  endtask

  initial begin
    int cnt, dn;
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    s_in_valid = 1'b0; s_in_x = '0; s_in_y = '0; s_in_colour = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_plot", plot, 0);
    chk("rst_done", done, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    reset = 1'b0;
    step();

    run_req(38, 4, 7, 9);
    run_req(158, 118, 5, 4);

    // held request: second box's first pixel 11 edges after first acceptance
    in_valid = 1'b1; in_x = 8'd43; in_y = 7'd7; in_colour = 3'd7;
    step();
    in_x = 8'd118; in_y = 7'd4; in_colour = 3'd2;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(plot && vga_x == 8'd118 && vga_y == 7'd4) && cnt < 30);
    chk("b2b_gap", cnt, 11);
    in_valid = 1'b0;
    while (k != 0) step();

    // reset during the 5th pixel
    in_valid = 1'b1; in_x = 8'd50; in_y = 7'd50; in_colour = 3'd3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_plot", plot, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_plot", plot, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ready", in_ready, 0);
    step();
    reset = 1'b0;
    dn = 0;
    repeat (12) begin step(); if (done) dn++; end
    chk("abort_no_done", dn, 0);
    run_req(10, 20, 6, 9);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 3 == 0);
      in_x = 8'($urandom); in_y = 7'($urandom); in_colour = 3'($urandom);
      if ($urandom % 150 == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    while (k != 0) step();

    // 1x1 instance
    s_in_valid = 1'b1; s_in_x = 8'd0; s_in_y = 7'd0; s_in_colour = 3'd5;
    step();
    s_in_valid = 1'b0; s_in_colour = 3'd1;
    chk("s_plot", s_plot, 1);
    chk("s_vga_x", s_vga_x, 0);
    chk("s_vga_y", s_vga_y, 0);
    chk("s_colour", s_vga_colour, 5);
    chk("s_ready_busy", s_in_ready, 0);
    chk("s_done_early", s_done, 0);
    step();
    chk("s_done", s_done, 1);
    chk("s_plot_done", s_plot, 0);
    chk("s_ready_done", s_in_ready, 0);
    step();
    chk("s_ready_idle", s_in_ready, 1);
    chk("s_done_idle", s_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
    $fatal(1, "timeout");
  end

endmodule
